// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: EX operand forwarding,
// load-use stalls, data-memory freeze and held redirects. Optional counters: HAZARD_PERF_EN.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  redirect,
    input  logic                  dmem_busy,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  stall_ex_mem,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  bubble_mem_wb,
    output logic                  redirect_go
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]      perf_lu_stalls,
    output logic [CNT_W-1:0]      perf_flushes,
    output logic [CNT_W-1:0]      perf_freeze_cycles
`endif
);

    localparam int LC_W = 3;
    localparam logic [LC_W-1:0] LU_RELOAD = LC_W'(LOAD_LAT - 1);

    typedef enum logic [1:0] {RUN, LU_STALL, FREEZE} state_t;

    state_t            state_q, state_d;
    logic [LC_W-1:0]   lu_cnt_q, lu_cnt_d;
    logic              pend_q, pend_d;
    logic              lu_hit, lu_bubble, freeze, take_redirect;

    logic [REG_ADDR_W-1:0] ex_rs [2];
    logic [1:0]            fwd   [2];

    assign ex_rs[0] = ex_rs1;
    assign ex_rs[1] = ex_rs2;

    // EX/MEM wins over MEM/WB; x0 is never forwarded.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd[gi] = 2'b00;
                if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs[gi]))
                    fwd[gi] = 2'b10;
                else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs[gi]))
                    fwd[gi] = 2'b01;
            end
        end
    endgenerate

    assign forward_a = fwd[0];
    assign forward_b = fwd[1];

    assign lu_hit = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d       = state_q;
        lu_cnt_d      = lu_cnt_q;
        pend_d        = pend_q;
        lu_bubble     = 1'b0;
        freeze        = 1'b0;
        take_redirect = 1'b0;
        case (state_q)
            RUN: begin
                if (dmem_busy) begin
                    freeze  = 1'b1;
                    pend_d  = redirect;
                    state_d = FREEZE;
                end else if (redirect) begin
                    take_redirect = 1'b1;
                end else if (lu_hit) begin
                    lu_bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        lu_cnt_d = LU_RELOAD;
                        state_d  = LU_STALL;
                    end
                end
            end
            LU_STALL: begin
                // A freeze holds the remaining bubble count untouched.
                if (dmem_busy) begin
                    freeze = 1'b1;
                end else begin
                    lu_bubble = 1'b1;
                    lu_cnt_d  = lu_cnt_q - LC_W'(1);
                    if (lu_cnt_q == LC_W'(1))
                        state_d = RUN;
                end
            end
            FREEZE: begin
                if (dmem_busy) begin
                    freeze = 1'b1;
                    pend_d = pend_q | redirect;
                end else if (pend_q) begin
                    take_redirect = 1'b1;
                    pend_d        = 1'b0;
                    state_d       = RUN;
                end else begin
                    state_d = RUN;
                    if (redirect) begin
                        take_redirect = 1'b1;
                    end else if (lu_hit) begin
                        lu_bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            lu_cnt_d = LU_RELOAD;
                            state_d  = LU_STALL;
                        end
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            lu_cnt_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            pend_q   <= pend_d;
        end
    end

    // Control outputs are forced low while reset is asserted, without waiting for a clock.
    assign stall_pc      = reset & (freeze | lu_bubble);
    assign stall_if_id   = reset & (freeze | lu_bubble);
    assign stall_id_ex   = reset & freeze;
    assign stall_ex_mem  = reset & freeze;
    assign bubble_mem_wb = reset & freeze;
    assign flush_if_id   = reset & take_redirect;
    assign flush_id_ex   = reset & (take_redirect | lu_bubble);
    assign redirect_go   = reset & take_redirect;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] lu_stalls_q, flushes_q, freeze_cycles_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lu_stalls_q     <= '0;
            flushes_q       <= '0;
            freeze_cycles_q <= '0;
        end else begin
            if (lu_bubble)     lu_stalls_q     <= lu_stalls_q + CNT_W'(1);
            if (take_redirect) flushes_q       <= flushes_q + CNT_W'(1);
            if (dmem_busy)     freeze_cycles_q <= freeze_cycles_q + CNT_W'(1);
        end
    end

    assign perf_lu_stalls     = lu_stalls_q;
    assign perf_flushes       = flushes_q;
    assign perf_freeze_cycles = freeze_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (LOAD_LAT=1 and 3) share stimulus and are
// compared every cycle against a model tracking owed bubbles and an owed redirect.
module tb_hazard_ctrl_unit;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_u1, id_u2, ex_mr, mem_rw, wb_rw, redir, busy;

    logic [1:0] fa [2];
    logic [1:0] fb [2];
    logic spc [2], sif [2], sie [2], sem [2], fif [2], fie [2], bmw [2], rgo [2];
`ifdef HAZARD_PERF_EN
    logic [31:0] p_lu [2], p_fl [2], p_fr [2];
`endif

    int total = 0;
    int bad   = 0;

    // Model state: bubbles still owed, redirect owed after a freeze, expected counters.
    int   lat  [2] = '{1, 3};
    int   rem  [2];
    bit   pend [2];
    int   m_lu [2], m_fl [2], m_fr [2];
    logic [11:0] got_vec [2];

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_ADDR_W(AW), .LOAD_LAT(1), .CNT_W(32)) u_lat1 (
        .clk(clk), .reset(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_u1), .id_uses_rs2(id_u2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mr),
        .mem_rd(mem_rd), .mem_reg_write(mem_rw), .wb_rd(wb_rd), .wb_reg_write(wb_rw),
        .redirect(redir), .dmem_busy(busy),
        .forward_a(fa[0]), .forward_b(fb[0]),
        .stall_pc(spc[0]), .stall_if_id(sif[0]), .stall_id_ex(sie[0]), .stall_ex_mem(sem[0]),
        .flush_if_id(fif[0]), .flush_id_ex(fie[0]), .bubble_mem_wb(bmw[0]), .redirect_go(rgo[0])
`ifdef HAZARD_PERF_EN
        , .perf_lu_stalls(p_lu[0]), .perf_flushes(p_fl[0]), .perf_freeze_cycles(p_fr[0])
`endif
    );

    hazard_ctrl_unit #(.REG_ADDR_W(AW), .LOAD_LAT(3), .CNT_W(32)) u_lat3 (
        .clk(clk), .reset(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_u1), .id_uses_rs2(id_u2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mr),
        .mem_rd(mem_rd), .mem_reg_write(mem_rw), .wb_rd(wb_rd), .wb_reg_write(wb_rw),
        .redirect(redir), .dmem_busy(busy),
        .forward_a(fa[1]), .forward_b(fb[1]),
        .stall_pc(spc[1]), .stall_if_id(sif[1]), .stall_id_ex(sie[1]), .stall_ex_mem(sem[1]),
        .flush_if_id(fif[1]), .flush_id_ex(fie[1]), .bubble_mem_wb(bmw[1]), .redirect_go(rgo[1])
`ifdef HAZARD_PERF_EN
        , .perf_lu_stalls(p_lu[1]), .perf_flushes(p_fl[1]), .perf_freeze_cycles(p_fr[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd_exp(input logic [AW-1:0] rs);
        if (mem_rw && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_rw && wb_rd != 0 && wb_rd == rs)    return 2'b01;
        return 2'b00;
    endfunction

    // Expected vector: {fa, fb, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    //                   flush_if_id, flush_id_ex, bubble_mem_wb, redirect_go}
    task automatic model_step(input int k, output logic [11:0] exp_vec);
        logic [7:0] ctl;
        bit lu;
        lu  = ex_mr && ex_rd != 0 && ((id_u1 && id_rs1 == ex_rd) || (id_u2 && id_rs2 == ex_rd));
        ctl = 8'b0;
        if (!rst_n) begin
            rem[k] = 0; pend[k] = 0;
        end else if (busy) begin
            ctl = 8'b1111_0010;
            m_fr[k]++;
            if (rem[k] == 0) pend[k] = pend[k] | redir;
        end else if (rem[k] > 0) begin
            ctl = 8'b1100_0100;
            rem[k]--; m_lu[k]++;
        end else if (pend[k] || redir) begin
            ctl = 8'b0000_1101;
            pend[k] = 0; m_fl[k]++;
        end else if (lu) begin
            ctl = 8'b1100_0100;
            rem[k] = lat[k] - 1; m_lu[k]++;
        end
        exp_vec = {fwd_exp(ex_rs1), fwd_exp(ex_rs2), ctl};
    endtask

    task automatic cycle(input string tag);
        logic [11:0] e;
        #2;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin m_lu[k] = 0; m_fl[k] = 0; m_fr[k] = 0; end
`ifdef HAZARD_PERF_EN
            check($sformatf("%s perf_lu[%0d]", tag, k), p_lu[k], m_lu[k]);
            check($sformatf("%s perf_fl[%0d]", tag, k), p_fl[k], m_fl[k]);
            check($sformatf("%s perf_fr[%0d]", tag, k), p_fr[k], m_fr[k]);
`endif
            model_step(k, e);
            got_vec[k] = {fa[k], fb[k], spc[k], sif[k], sie[k], sem[k], fif[k], fie[k], bmw[k], rgo[k]};
            check($sformatf("%s lat%0d", tag, lat[k]), {20'b0, got_vec[k]}, {20'b0, e});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_u1, id_u2, ex_mr, mem_rw, wb_rw, redir, busy} = '0;
    endtask

    task automatic set_lu();
        ex_mr = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_u2 = 1'b1;
    endtask

    initial begin
        int n_spc [2];
        int n_bmw, n_rgo;
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; pend[k] = 0; m_lu[k] = 0; m_fl[k] = 0; m_fr[k] = 0;
        end
        idle();
        rst_n = 1'b0;
        cycle("reset");
        check("reset ctl", {24'b0, got_vec[1][7:0]}, 32'h0);
        rst_n = 1'b1;
        cycle("idle");

        // Forwarding priority and x0 handling
        ex_rs1 = 5'd5; mem_rd = 5'd5; mem_rw = 1'b1; wb_rd = 5'd5; wb_rw = 1'b1;
        cycle("fwd both");
        check("fwd_a exmem", {30'b0, got_vec[0][11:10]}, 32'h2);
        mem_rd = 5'd0;
        cycle("fwd wb");
        check("fwd_a memwb", {30'b0, got_vec[0][11:10]}, 32'h1);
        wb_rd = 5'd0;
        cycle("fwd none");
        check("fwd_a none", {30'b0, got_vec[0][11:10]}, 32'h0);

        // Single load-use hazard: LOAD_LAT bubbles each
        idle();
        n_spc = '{0, 0};
        for (int i = 0; i < 6; i++) begin
            if (i == 0) set_lu(); else idle();
            cycle("loaduse");
            for (int k = 0; k < 2; k++) n_spc[k] += int'(got_vec[k][7]);
        end
        check("lu bubbles lat1", n_spc[0], 1);
        check("lu bubbles lat3", n_spc[1], 3);

        // Redirect beats load-use in the same cycle
        set_lu(); redir = 1'b1;
        cycle("redir+lu");
        check("redir go", {31'b0, got_vec[1][0]}, 32'h1);
        check("redir no stall", {31'b0, got_vec[1][7]}, 32'h0);
        idle();
        cycle("after redir");
        check("after redir run", {31'b0, got_vec[1][7]}, 32'h0);

        // 4-cycle freeze with redirect in cycle 2: redirect_go on cycle 5 only
        n_bmw = 0; n_rgo = 0;
        for (int i = 1; i <= 6; i++) begin
            idle();
            busy  = (i <= 4);
            redir = (i == 2);
            cycle("freeze");
            n_bmw += int'(got_vec[0][1]);
            n_rgo += int'(got_vec[0][0]);
            if (i == 5) check("freeze redir_go c5", {31'b0, got_vec[0][0]}, 32'h1);
        end
        check("freeze bubbles", n_bmw, 4);
        check("freeze redir_go count", n_rgo, 1);

        // Asynchronous reset while LAT=3 instance sits in LU_STALL with lu_cnt=2
        set_lu();
        cycle("lu before reset");
        rst_n = 1'b0;
        cycle("reset mid-stall");
        check("reset mid-stall ctl", {24'b0, got_vec[1][7:0]}, 32'h0);
        idle();
        rst_n = 1'b1;
        cycle("after reset");
        check("after reset run", {31'b0, got_vec[1][7]}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
            ex_rs1 = AW'($urandom_range(0, 3)); ex_rs2 = AW'($urandom_range(0, 3));
            ex_rd  = AW'($urandom_range(0, 3)); mem_rd = AW'($urandom_range(0, 3));
            wb_rd  = AW'($urandom_range(0, 3));
            id_u1  = 1'($urandom_range(0, 1)); id_u2 = 1'($urandom_range(0, 1));
            ex_mr  = ($urandom_range(0, 9) < 4);
            mem_rw = 1'($urandom_range(0, 1)); wb_rw = 1'($urandom_range(0, 1));
            redir  = ($urandom_range(0, 9) < 2);
            busy   = ($urandom_range(0, 9) < 3);
            rst_n  = ($urandom_range(0, 99) != 0);
            cycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB); replaces the bare forwarding_unit.
- Produces EX operand forward selects.
- Detects load-use hazards and generates a multi-cycle stall.
- Freezes the pipeline while data memory is busy, and holds a branch/jump redirect that arrives during a freeze until it can be applied.

Parameters:
- REG_ADDR_W, 5, register address width; x0 is the all-zero address.
- LOAD_LAT, 1, bubble cycles per load-use hazard (1..7).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1 / rs2.
- ex_rs1, ex_rs2  in  REG_ADDR_W  source registers held in ID/EX.
- ex_rd  in  REG_ADDR_W  destination register in ID/EX.
- ex_mem_read  in  1  instruction in ID/EX is a load.
- mem_rd  in  REG_ADDR_W  destination register in EX/MEM.
- mem_reg_write  in  1  EX/MEM instruction writes rd.
- wb_rd  in  REG_ADDR_W  destination register in MEM/WB.
- wb_reg_write  in  1  MEM/WB instruction writes rd.
- redirect  in  1  taken branch / jal / jalr resolved in EX this cycle.
- dmem_busy  in  1  data memory has not completed its access.
- forward_a, forward_b  out  2  operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1  hold the PC / the named pipeline register.
- flush_if_id, flush_id_ex  out  1  squash the named register to a NOP.
- bubble_mem_wb  out  1  load a NOP into MEM/WB.
- redirect_go  out  1  PC takes the redirect target this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, lu_cnt=0, pend_redirect=0.
  - All stall, flush and bubble outputs are 0; redirect_go=0.
  - Reset takes effect mid-stall or mid-freeze, and any held redirect is discarded.
- Forwarding (combinational, independent of state), shown for operand A; operand B is identical using ex_rs2:
  - forward_a=10 if mem_reg_write and mem_rd!=0 and mem_rd==ex_rs1.
  - Otherwise 01 if wb_reg_write and wb_rd!=0 and wb_rd==ex_rs1.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB; x0 is never forwarded.
- Load-use hazard (lu_hit) is asserted when all of the following hold:
  - ex_mem_read is 1 and ex_rd!=0;
  - either (id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd).
- Outputs are combinational from state and inputs. Priority within a cycle: dmem_busy > redirect > load-use.
- State RUN:
  - dmem_busy=1: stall_pc, stall_if_id, stall_id_ex and stall_ex_mem are all 1; bubble_mem_wb=1; pend_redirect is set to redirect; next state FREEZE.
  - Else redirect=1: redirect_go=1, flush_if_id=1, flush_id_ex=1; any lu_hit is ignored.
  - Else lu_hit=1: stall_pc=1, stall_if_id=1, flush_id_ex=1 (bubble). If LOAD_LAT>1, lu_cnt is set to LOAD_LAT-1 and next state is LU_STALL.
- State LU_STALL:
  - stall_pc=1, stall_if_id=1, flush_id_ex=1; lu_cnt decrements each cycle.
  - Return to RUN on the cycle lu_cnt is 1.
  - If dmem_busy=1, freeze behaviour overrides: stall_pc, stall_if_id, stall_id_ex and stall_ex_mem are all 1 and bubble_mem_wb=1; lu_cnt is held (not decremented).
  - A redirect cannot occur here because EX holds a bubble; if it is asserted anyway, it is ignored.
- State FREEZE:
  - While dmem_busy=1: stall_pc, stall_if_id, stall_id_ex and stall_ex_mem are all 1; bubble_mem_wb=1; pend_redirect |= redirect.
  - On the first cycle dmem_busy=0: if pend_redirect was set, assert redirect_go, flush_if_id and flush_id_ex, then clear pend_redirect; otherwise evaluate as in RUN.
  - The next state is LU_STALL if lu_cnt!=0, else RUN.
- Latency: a single load-use hazard costs exactly LOAD_LAT bubbles; a redirect costs 2 squashed slots.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs perf_lu_stalls, perf_flushes and perf_freeze_cycles, each CNT_W bits.
  - perf_lu_stalls increments on every cycle with a load-use bubble.
  - perf_flushes increments on every redirect_go.
  - perf_freeze_cycles increments on every cycle with dmem_busy=1.
  - All counters reset to 0, wrap modulo 2^CNT_W, and saturate nowhere.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Double-hazard forwarding: ex_rs1=5, mem_rd=5/mem_reg_write=1, wb_rd=5/wb_reg_write=1 -> forward_a=10. Same stimulus with mem_rd=0 -> 01. Set all rd=0 -> 00.
- Load-use, LOAD_LAT=1 then 3: ex_mem_read=1, ex_rd=7, id_rs2=7, id_uses_rs2=1 -> stall_pc, stall_if_id and flush_id_ex held for exactly 1 cycle (LOAD_LAT=1), then exactly 3 cycles (LOAD_LAT=3); 0 afterwards.
- Redirect and lu_hit asserted in the same RUN cycle -> redirect_go=1, flush_if_id=1, flush_id_ex=1, stall_pc=0; the next state is RUN.
- dmem_busy high for 4 cycles with redirect pulsed in cycle 2 -> all stalls and bubble_mem_wb=1 for 4 cycles; redirect_go=1 on cycle 5 only.
- reset driven low while in LU_STALL with lu_cnt=2 -> all outputs 0 immediately (without waiting for a clock edge); the state after release is RUN.
- HAZARD_PERF_EN defined: run 2 load-use hazards (LOAD_LAT=1), 1 redirect and a 3-cycle freeze -> counters read 2, 1 and 3 respectively.
